// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// Output handshake: rx_valid is a one-cycle strobe with rx_byte valid in the
// same cycle. There is no ready/backpressure, so the consumer must take
// rx_byte before the next good frame overwrites it. rx_frame_err is a
// one-cycle strobe, never coincident with rx_valid.
module uart_rx #(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_rx_m;
    logic          r_rx_s;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_frame_err;
    logic          w_shift_en;
    logic          w_valid_set;
    logic          w_err_set;
    logic          w_cnt_clr;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath.
    always_comb begin
        w_next      = r_state;
        w_shift_en  = 1'b0;
        w_valid_set = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_next = S_START;
            end
            S_START: begin
                // Mid-bit recheck rejects short glitches.
                if (r_cnt == CNT_HALF) w_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_shift_en = 1'b1;
                    if (r_idx == 3'd7) w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    if (r_rx_s) begin
                        w_valid_set = 1'b1;
                        w_next      = S_IDLE;
                    end else begin
                        w_err_set = 1'b1;
                        w_next    = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold here until the line goes high so a break is not
                // decoded as a stream of zero bytes.
                if (r_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Counter restarts on every state entry and once per bit period.
    assign w_cnt_clr = (w_next != r_state) || (r_state == S_IDLE) || (r_cnt == CNT_LAST);

    // Bit-timing counter, bit index, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_byte      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            r_valid     <= w_valid_set;
            r_frame_err <= w_err_set;
            if (r_state == S_IDLE) begin
                r_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_idx   <= r_idx + 3'd1;
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
            if (w_valid_set) r_byte <= r_shift;
        end
    end

    assign rx_byte      = r_byte;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state != S_IDLE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx at the default 104 clk/bit.
module tb_uart_rx;

    localparam int CPB = 104;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         tv_q[$];
    int         ts_q[$];
    int         n_total  = 0;
    int         n_bad    = 0;
    int         n_err    = 0;
    int         n_both   = 0;
    int         n_consec = 0;
    int         busy_cnt = 0;
    logic       prev_pulse = 1'b0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_byte);
            tv_q.push_back(cyc);
        end
        if (rx_frame_err) n_err++;
        if (rx_valid && rx_frame_err) n_both++;
        if ((rx_valid || rx_frame_err) && prev_pulse) n_consec++;
        prev_pulse = rx_valid || rx_frame_err;
        if (rx_busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int cpb);
        rx = b;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input int cpb, input logic stop);
        ts_q.push_back(cyc);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
        send_bit(stop, cpb);
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int       lat;
        int       t0;
        logic [7:0] v96;

        // Reset
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_byte",  rx_byte, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr",  rx_frame_err, 0);
        check("rst_busy",  rx_busy, 0);
        rst_n = 1'b1;

        // Long idle line
        busy_cnt = 0;
        idle(2000);
        check("idle_valid", got_q.size(), 0);
        check("idle_ferr",  n_err, 0);
        check("idle_busy",  busy_cnt, 0);
        check("idle_byte",  rx_byte, 8'h00);

        // Single frame 0xA5 with latency check
        tv_q.delete();
        ts_q.delete();
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, CPB, 1'b1);
        idle(20);
        if (tv_q.size() > 0 && ts_q.size() > 0) begin
            lat = tv_q[0] - ts_q[0];
            check("a5_lat", (lat >= 988 && lat <= 994) ? lat : -1, lat);
            check("a5_lat_nom", (lat >= 988 && lat <= 994) ? 1 : 0, 1);
        end
        check_frames("a5");
        check("a5_ferr", n_err, 0);

        // Back-to-back frames, one stop bit each
        tv_q.delete();
        ts_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_byte(8'h00, CPB, 1'b1);
        send_byte(8'hFF, CPB, 1'b1);
        send_byte(8'h55, CPB, 1'b1);
        idle(20);
        check("b2b_pulses", tv_q.size(), 3);
        if (tv_q.size() == 3) begin
            check("b2b_gap1", tv_q[1] - tv_q[0], 1040);
            check("b2b_gap2", tv_q[2] - tv_q[1], 1040);
        end
        check_frames("b2b");

        // Start-bit glitch
        t0 = cyc;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy_hi", rx_busy, 1);
        rx = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!rx_busy) break;
            @(negedge clk);
        end
        check("glitch_busy_fall", ((cyc - t0) <= 55 && !rx_busy) ? 1 : 0, 1);
        idle(200);
        check("glitch_valid", got_q.size(), 0);
        check("glitch_ferr",  n_err, 0);

        // Framing error followed by a held-low break
        send_byte(8'h3C, CPB, 1'b0);
        rx = 1'b0;
        repeat (3000) @(negedge clk);
        check("brk_busy",      rx_busy, 1);
        check("brk_ferr_hold", n_err, 1);
        idle(200);
        check("brk_ferr",      n_err, 1);
        check("brk_valid",     got_q.size(), 0);
        check("brk_byte_hold", rx_byte, 8'h55);
        check("brk_busy_low",  rx_busy, 0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, CPB, 1'b1);
        idle(20);
        check_frames("after_brk");

        // Reset during data bit 4 of 0x96, then line returns to idle
        v96 = 8'h96;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(v96[i], CPB);
        rx = v96[4];
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_busy0", rx_busy, 0);
        idle(1200);
        check("rst_mid_valid", got_q.size(), 0);
        check("rst_mid_ferr",  n_err, 1);
        check("rst_mid_byte",  rx_byte, 8'h00);
        check("rst_mid_busy",  rx_busy, 0);
        exp_q.push_back(8'h42);
        send_byte(8'h42, CPB, 1'b1);
        idle(20);
        check_frames("after_rst");

        // Baud tolerance: -4% and +4%
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 100, 1'b1);
        idle(20);
        check("fast_byte", rx_byte, 8'h5A);
        check_frames("fast");
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 108, 1'b1);
        idle(20);
        check("slow_byte", rx_byte, 8'h5A);
        check_frames("slow");

        // Strobe relationships over the whole run
        check("strobe_excl",   n_both, 0);
        check("strobe_consec", n_consec, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
